// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing one slave port among NUM_M bus masters.
// Master 0 is the core data port; one outstanding transaction, per-transaction timeout.
module rib_arbiter #(
    parameter int NUM_M   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_M-1:0]          m_req_i,
    input  logic [NUM_M-1:0]          m_wr_en_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata_i,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic                      m_err_o,
    output logic [DATA_W-1:0]         m_rdata_o,
    output logic                      s_req_o,
    output logic                      s_wr_en_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_wdata_o,
    input  logic [DATA_W-1:0]         s_rdata_i,
    input  logic                      s_ack_i,
    output logic                      hold_flag_o
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_M - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_M-1:0]    ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                s_req_q, s_req_d;
    logic                s_wr_q, s_wr_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;

    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    idx;
    logic                found;
    logic [NUM_M-1:0]    grant_onehot;

    // Walk the masters starting just after the last winner, wrapping at NUM_M-1.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = last_q;
        for (int off = 0; off < NUM_M; off++) begin
            idx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            if (!found && m_req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant_onehot = NUM_M'(1) << grant_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        s_req_d   = s_req_q;
        s_wr_d    = s_wr_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d   = ST_BUSY;
                    grant_d   = winner;
                    last_d    = winner;
                    s_req_d   = 1'b1;
                    s_wr_d    = m_wr_en_i[winner];
                    s_addr_d  = m_addr_i[winner*ADDR_W +: ADDR_W];
                    s_wdata_d = m_wdata_i[winner*DATA_W +: DATA_W];
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A slave ack on the final cycle still counts as success.
                if (s_ack_i) begin
                    state_d = ST_RESP;
                    ack_d   = grant_onehot;
                    rdata_d = s_wr_q ? '0 : s_rdata_i;
                    s_req_d = 1'b0;
                    s_wr_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    ack_d   = grant_onehot;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    s_req_d = 1'b0;
                    s_wr_d  = 1'b0;
                end
            end

            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_LAST;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            s_req_q   <= 1'b0;
            s_wr_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            s_req_q   <= s_req_d;
            s_wr_q    <= s_wr_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    assign m_ack_o     = ack_q;
    assign m_err_o     = err_q;
    assign m_rdata_o   = rdata_q;
    assign s_req_o     = s_req_q;
    assign s_wr_en_o   = s_wr_q;
    assign s_addr_o    = s_addr_q;
    assign s_wdata_o   = s_wdata_q;
    assign hold_flag_o = m_req_i[0] & ~ack_q[0];

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: vector table plus hand-written round-robin,
// idle-ack and mid-transaction reset sequences, checked through a scoreboard queue.
module tb_rib_arbiter;

    localparam int NUM_M   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_M-1:0]        m_req_i;
    logic [NUM_M-1:0]        m_wr_en_i;
    logic [NUM_M*ADDR_W-1:0] m_addr_i;
    logic [NUM_M*DATA_W-1:0] m_wdata_i;
    logic [NUM_M-1:0]        m_ack_o;
    logic                    m_err_o;
    logic [DATA_W-1:0]       m_rdata_o;
    logic                    s_req_o;
    logic                    s_wr_en_o;
    logic [ADDR_W-1:0]       s_addr_o;
    logic [DATA_W-1:0]       s_wdata_o;
    logic [DATA_W-1:0]       s_rdata_i;
    logic                    s_ack_i;
    logic                    hold_flag_o;

    rib_arbiter #(
        .NUM_M  (NUM_M),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req_i    (m_req_i),
        .m_wr_en_i  (m_wr_en_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .m_rdata_o  (m_rdata_o),
        .s_req_o    (s_req_o),
        .s_wr_en_o  (s_wr_en_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_rdata_i  (s_rdata_i),
        .s_ack_i    (s_ack_i),
        .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;   // slave acks at the delay-th BUSY edge; 0 = never
        logic [31:0] srdata;
        int          grant;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          grant;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   sb_grant[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input logic [31:0] srdata,
                                input int grant, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata; v.delay = delay;
        v.srdata = srdata; v.grant = grant; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic run_vector(input vec_t v);
        exp_t e;
        exp_t got_e;
        int   n;
        int   exp_busy;
        bit   rose;
        bit   got;
        e.grant = v.grant;
        e.err   = v.err;
        e.rdata = v.rdata;
        e.addr  = v.addr;
        e.wr    = v.wr[v.grant];
        e.wdata = v.wdata;
        sb.push_back(e);
        exp_busy = (v.delay >= 1 && v.delay <= TIMEOUT) ? v.delay : TIMEOUT;

        m_req_i   = v.req;
        m_wr_en_i = v.wr;
        for (int i = 0; i < NUM_M; i++) begin
            m_addr_i[i*ADDR_W +: ADDR_W]  = (i == v.grant) ? v.addr  : ~v.addr;
            m_wdata_i[i*DATA_W +: DATA_W] = (i == v.grant) ? v.wdata : ~v.wdata;
        end
        s_ack_i = 1'b0;

        rose = 1'b0;
        for (int c = 0; c < 10 && !rose; c++) begin
            @(negedge clk);
            rose = s_req_o;
        end
        check("s_req_rise", rose, 1);
        check("s_addr", s_addr_o, sb[0].addr);
        check("s_wr_en", s_wr_en_o, sb[0].wr);
        check("s_wdata", s_wdata_o, sb[0].wdata);
        check("hold_busy", hold_flag_o, v.req[0]);

        n   = 0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (s_req_o) n++;
            s_ack_i   = (v.delay == c);
            s_rdata_i = (v.delay == c) ? v.srdata : $urandom;
            @(negedge clk);
            s_ack_i = 1'b0;
            got     = (m_ack_o != '0);
        end
        check("ack_seen", got, 1);
        check("busy_cycles", n, exp_busy);

        if (got && sb.size() > 0) begin
            got_e = sb.pop_front();
            check("m_ack", m_ack_o, 64'(4'b0001 << got_e.grant));
            check("m_err", m_err_o, got_e.err);
            check("m_rdata", m_rdata_o, got_e.rdata);
            check("s_req_fall", s_req_o, 0);
            check("hold_ack", hold_flag_o, (got_e.grant == 0) ? 1'b0 : v.req[0]);
            m_req_i = '0;
            @(negedge clk);
            check("ack_pulse_end", m_ack_o, 0);
            check("err_pulse_end", m_err_o, 0);
            check("rdata_hold", m_rdata_o, got_e.rdata);
        end else begin
            sb.delete();
            m_req_i = '0;
            @(negedge clk);
        end
    endtask

    vec_t tbl[8];
    vec_t after_rst;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g;
        int got_n;
        int last_c;

        tbl[0] = mk(4'b0001, 4'b0000, 32'h1000_0004, 32'h0000_0000, 2, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
        tbl[1] = mk(4'b0100, 4'b0100, 32'h2000_0010, 32'h1234_5678, 1, 32'hAAAA_5555, 2, 1'b0, 32'h0000_0000);
        tbl[2] = mk(4'b0010, 4'b0000, 32'h3000_0000, 32'h0000_0000, 0, 32'h0000_0000, 1, 1'b1, 32'h0000_0000);
        tbl[3] = mk(4'b1010, 4'b0010, 32'h4000_0008, 32'hCAFE_0001, 1, 32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D);
        tbl[4] = mk(4'b1011, 4'b0001, 32'h5000_0000, 32'h7777_8888, 3, 32'h5A5A_5A5A, 0, 1'b0, 32'h0000_0000);
        tbl[5] = mk(4'b1010, 4'b0000, 32'h6000_0040, 32'h0000_0000, 8, 32'hFEED_F00D, 1, 1'b0, 32'hFEED_F00D);
        tbl[6] = mk(4'b1111, 4'b1011, 32'h7000_0000, 32'h0000_0000, 1, 32'h1111_2222, 2, 1'b0, 32'h1111_2222);
        tbl[7] = mk(4'b0101, 4'b0100, 32'h8000_0000, 32'h0000_0000, 2, 32'h1357_9BDF, 0, 1'b0, 32'h1357_9BDF);
        after_rst = mk(4'b1000, 4'b0000, 32'h9000_0000, 32'h0000_0000, 1, 32'h2468_ACE0, 3, 1'b0, 32'h2468_ACE0);

        rst_n     = 1'b0;
        m_req_i   = '0;
        m_wr_en_i = '0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        s_rdata_i = '0;
        s_ack_i   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", m_ack_o, 0);
        check("rst_err", m_err_o, 0);
        check("rst_rdata", m_rdata_o, 0);
        check("rst_s_req", s_req_o, 0);
        check("rst_s_addr", s_addr_o, 0);
        check("rst_hold", hold_flag_o, 0);
        rst_n = 1'b1;

        // Round-robin from reset: everyone requests, slave acks as soon as it sees s_req_o.
        for (int i = 0; i < NUM_M; i++) begin
            m_addr_i[i*ADDR_W +: ADDR_W] = 32'h100 * i;
        end
        sb_grant = '{0, 1, 2, 3, 0};
        m_req_i  = 4'b1111;
        got_n    = 0;
        last_c   = -1;
        for (int c = 0; c < 30 && got_n < 5; c++) begin
            s_ack_i = s_req_o;
            @(negedge clk);
            if (m_ack_o != '0 && sb_grant.size() > 0) begin
                exp_g = sb_grant.pop_front();
                check("rr_ack", m_ack_o, 64'(4'b0001 << exp_g));
                if (last_c >= 0) check("rr_spacing", c - last_c, 3);
                last_c = c;
                got_n++;
            end
        end
        check("rr_count", got_n, 5);
        m_req_i = '0;
        s_ack_i = 1'b0;
        @(negedge clk);
        check("rr_ack_end", m_ack_o, 0);

        for (int i = 0; i < 8; i++) begin
            run_vector(tbl[i]);
        end

        // Slave ack while idle must be ignored.
        s_ack_i   = 1'b1;
        s_rdata_i = 32'hBADB_AD00;
        repeat (2) begin
            @(negedge clk);
            check("idle_ack_ignored", m_ack_o, 0);
        end
        check("idle_no_req", s_req_o, 0);
        check("idle_rdata_kept", m_rdata_o, 32'h1357_9BDF);
        s_ack_i = 1'b0;

        // Reset in the middle of a transaction.
        m_req_i   = 4'b0010;
        m_wr_en_i = 4'b0010;
        m_addr_i  = {4{32'hA5A5_0000}};
        m_wdata_i = {4{32'h0F0F_0F0F}};
        got_n = 0;
        for (int c = 0; c < 10 && got_n == 0; c++) begin
            @(negedge clk);
            if (s_req_o) got_n = 1;
        end
        check("mid_busy_reached", got_n, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", m_ack_o, 0);
        check("async_rst_err", m_err_o, 0);
        check("async_rst_rdata", m_rdata_o, 0);
        check("async_rst_s_req", s_req_o, 0);
        check("async_rst_s_wr", s_wr_en_o, 0);
        check("async_rst_s_addr", s_addr_o, 0);
        check("async_rst_s_wdata", s_wdata_o, 0);
        m_req_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vector(after_rst);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Shares one peripheral/memory slave port among NUM_M bus masters. Master 0 is the core data port (perip_req/perip_wr_en/perip_addr/perip_data); masters 1..NUM_M-1 are JTAG debug, DMA, and similar.
- Round-robin arbitration, one outstanding transaction at a time, with a per-transaction timeout.
- Drives the core's rib_hold_flag_i input through hold_flag_o, so the pipeline stalls while the core's access is pending.

Parameters:
- NUM_M, 4, number of masters (2..8); index 0 is the core.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max BUSY cycles waiting for s_ack_i (1..65535); counter width 16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req_i  in  NUM_M  per-master request, held high until that master's ack.
- m_wr_en_i  in  NUM_M  per-master write (1) / read (0).
- m_addr_i  in  NUM_M*ADDR_W  packed addresses; master i at bits [i*ADDR_W +: ADDR_W].
- m_wdata_i  in  NUM_M*DATA_W  packed write data.
- m_ack_o  out  NUM_M  one-hot, one-cycle completion pulse.
- m_err_o  out  1  valid with m_ack_o; 1 = timeout.
- m_rdata_o  out  DATA_W  read data, valid with m_ack_o (shared by all masters).
- s_req_o  out  1  slave request.
- s_wr_en_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_rdata_i  in  DATA_W  slave read data, sampled when s_ack_i=1.
- s_ack_i  in  1  slave completion, single cycle.
- hold_flag_o  out  1  combinational: m_req_i[0] & ~m_ack_o[0].

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, last_grant=NUM_M-1, timeout counter=0.
  - All registered outputs go to 0: m_ack_o, m_err_o, m_rdata_o, s_req_o, s_wr_en_o, s_addr_o, s_wdata_o.
  - An in-flight transaction is dropped silently.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If m_req_i!=0, select the first set bit searching last_grant+1, last_grant+2, ... with wrap-around modulo NUM_M.
  - In the same edge: grant<=winner, last_grant<=winner; latch s_addr_o, s_wdata_o and the winner's write bit; go to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - s_req_o=1 and s_wr_en_o=latched write bit, both registered (they rise on the IDLE->BUSY edge).
  - The counter increments each BUSY cycle.
  - If s_ack_i=1 at an edge: m_rdata_o<=s_rdata_i (reads), or 0 for writes; m_ack_o[grant]<=1; m_err_o<=0; go to RESP. s_req_o and s_wr_en_o fall on this same edge.
  - Else if counter==TIMEOUT-1: m_ack_o[grant]<=1, m_err_o<=1, m_rdata_o<=0; go to RESP.
  - s_ack_i takes priority over timeout when both occur on the same edge.
  - Master inputs are ignored during BUSY. A master dropping its request does not abort a committed transaction.
- RESP:
  - Lasts exactly one cycle: ack pulse visible, no arbitration.
  - The counter clears; next state is IDLE.
  - m_ack_o and m_err_o return to 0 on leaving RESP.
  - m_rdata_o holds its value until the next RESP.
- Latency:
  - Request seen at edge 0 (IDLE) gives s_req_o high from cycle 1.
  - Slave ack at edge k (k>=1) gives m_ack_o high during cycle k+1.
  - Arbitration resumes at edge k+2.
  - Minimum 3 cycles per transaction.
- Masters must deassert the request, or present a new transaction, in the cycle after their ack. A request still high in IDLE starts a new transaction.
- Fairness: a continuously requesting master is granted within NUM_M transactions.
- s_ack_i while not in BUSY: ignored.

Test Plan:
- Single core read: m_req_i=4'b0001, addr 0x1000_0004, slave acks 2 cycles after s_req_o with rdata 0xDEAD_BEEF -> s_addr_o=0x1000_0004, s_wr_en_o=0; m_ack_o=0001 one cycle later with m_rdata_o=0xDEADBEEF, m_err_o=0; hold_flag_o high from request until the ack cycle.
- Round-robin: all four request continuously from reset, slave acks immediately -> grant order 0,1,2,3,0; each m_ack_o a one-hot single pulse, 3 cycles apart.
- Write pass-through: master 2 writes 0x1234_5678 to 0x2000_0010 -> s_wr_en_o=1, s_wdata_o=0x12345678, s_addr_o=0x20000010; m_ack_o=0100; m_rdata_o=0.
- Timeout: TIMEOUT=8, master 1 reads, no s_ack_i -> s_req_o high exactly 8 cycles, then m_ack_o=0010, m_err_o=1, m_rdata_o=0; next grant proceeds normally.
- Simultaneous ack and timeout at the same edge -> m_err_o=0, data taken from s_rdata_i.
- Reset asserted mid-BUSY -> all outputs 0 immediately (async); after release with m_req_i=1000, master 3 is granted first (last_grant=3 search starts at 0; only master 3 is requesting).
